input_debouncer: RTL and testbench

//   Cleans a raw asynchronous input (button, external strobe) before edge/pulse

---
 rtl/input_debouncer.sv | 151 +++++++++++++++
 tb/tb_input_debouncer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input: synchronises it into clk, accepts a new level
// only after STABLE_CYCLES equal samples, and emits registered rise/fall/glitch strobes.
module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_async,
  output logic a_clean,
  output logic rise,
  output logic fall,
  output logic glitch
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_LOW      = 2'b00,
    ST_CHK_HIGH = 2'b01,
    ST_HIGH     = 2'b10,
    ST_CHK_LOW  = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   a_s;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   glitch_q, glitch_d;

  // Synchroniser chain; a_async feeds the first flop directly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a_async};
    end
  end

  assign a_s = sync_q[SYNC_STAGES-1];

  // Next-state logic: a check state counts agreeing samples; any disagreement abandons it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (a_s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = ST_HIGH;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_CHK_HIGH;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_CHK_HIGH: begin
        if (!a_s) begin
          state_d  = ST_LOW;
          glitch_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!a_s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = ST_LOW;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_CHK_LOW;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_CHK_LOW: begin
        if (a_s) begin
          state_d  = ST_HIGH;
          glitch_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // The clean level is a pure function of the next state, so it switches with the strobe.
  always_comb begin
    clean_d = 1'b0;
    if ((state_d == ST_HIGH) || (state_d == ST_CHK_LOW)) begin
      clean_d = 1'b1;
    end else begin
      clean_d = 1'b0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      clean_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clean_q  <= clean_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign a_clean = clean_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign glitch  = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: two instances (2/4 and 3/1) driven with the same stimulus,
// compared against vector tables, targeted sequences and a run-length reference model.
module tb_input_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic a_async;
  logic clean_a, rise_a, fall_a, glitch_a;
  logic clean_b, rise_b, fall_b, glitch_b;

  always #5 clk = ~clk;

  input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .a_async(a_async),
    .a_clean(clean_a), .rise(rise_a), .fall(fall_a), .glitch(glitch_a)
  );

  input_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .a_async(a_async),
    .a_clean(clean_b), .rise(rise_b), .fall(fall_b), .glitch(glitch_b)
  );

  // Reference model: delay line of raw samples plus length of the current disagreeing run.
  typedef struct {
    bit [7:0] pipe;
    int       run;
    bit       clean;
    bit       rise;
    bit       fall;
    bit       glitch;
  } mdl_t;

  typedef struct {
    bit       r;
    bit       a;
    bit [3:0] exp;
  } vec_t;

  mdl_t ma, mb;
  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;
  int   tick_no = 0;
  int   n_rise[2], n_fall[2], n_glitch[2], n_high[2], rise_edge[2], fall_edge[2];

  function automatic mdl_t mstep(mdl_t m, bit r, bit a, int ns, int nst);
    mdl_t n;
    bit   v;
    n = m;
    n.rise = 1'b0;
    n.fall = 1'b0;
    n.glitch = 1'b0;
    if (!r) begin
      n.pipe = 8'd0;
      n.run = 0;
      n.clean = 1'b0;
      return n;
    end
    v = m.pipe[ns-1];
    if (v != m.clean) begin
      n.run = m.run + 1;
      if (n.run >= nst) begin
        n.clean = v;
        n.rise = v;
        n.fall = !v;
        n.run = 0;
      end
    end else begin
      n.glitch = (m.run > 0);
      n.run = 0;
    end
    n.pipe = {m.pipe[6:0], a};
    return n;
  endfunction

  task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s tick=%0d: got {clean,rise,fall,glitch}=%b expected=%b", name, tick_no, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      n_rise[k] = 0; n_fall[k] = 0; n_glitch[k] = 0; n_high[k] = 0;
      rise_edge[k] = -1; fall_edge[k] = -1;
    end
    tick_no = 0;
  endtask

  task automatic tick(input bit r, input bit a);
    rst = r;
    a_async = a;
    @(posedge clk);
    #1;
    ma = mstep(ma, r, a, 2, 4);
    mb = mstep(mb, r, a, 3, 1);
    chk4("model_a", {clean_a, rise_a, fall_a, glitch_a}, {ma.clean, ma.rise, ma.fall, ma.glitch});
    chk4("model_b", {clean_b, rise_b, fall_b, glitch_b}, {mb.clean, mb.rise, mb.fall, mb.glitch});
    if (rise_a === 1'b1) begin n_rise[0]++; rise_edge[0] = tick_no; end
    if (fall_a === 1'b1) begin n_fall[0]++; fall_edge[0] = tick_no; end
    if (glitch_a === 1'b1) n_glitch[0]++;
    if (clean_a === 1'b1) n_high[0]++;
    if (rise_b === 1'b1) begin n_rise[1]++; rise_edge[1] = tick_no; end
    if (fall_b === 1'b1) begin n_fall[1]++; fall_edge[1] = tick_no; end
    if (glitch_b === 1'b1) n_glitch[1]++;
    if (clean_b === 1'b1) n_high[1]++;
    tick_no++;
  endtask

  function automatic void push(bit r, bit a, bit [3:0] e);
    vec_t v;
    v.r = r;
    v.a = a;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    int  len;
    bit  lvl;
    rst = 1'b0;
    a_async = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};
    clear_counts();

    // Expected outputs of the 2/4 instance, one record per clock edge.
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 4'b0000);
    for (int i = 1; i <= 20; i++) push(1'b1, 1'b1, (i < 6) ? 4'b0000 : ((i == 6) ? 4'b1100 : 4'b1000));
    for (int i = 1; i <= 20; i++) push(1'b1, 1'b0, (i < 6) ? 4'b1000 : ((i == 6) ? 4'b0010 : 4'b0000));
    push(1'b1, 1'b1, 4'b0000);
    push(1'b1, 1'b1, 4'b0000);
    for (int i = 3; i <= 10; i++) push(1'b1, 1'b0, (i == 5) ? 4'b0001 : 4'b0000);

    foreach (vecs[i]) begin
      tick(vecs[i].r, vecs[i].a);
      chk4("table_a", {clean_a, rise_a, fall_a, glitch_a}, vecs[i].exp);
    end

    // Bounce 1,0,1,0,1 then steady 1: two abandoned checks then one rise at edge 9.
    clear_counts();
    tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b0);
    for (int i = 0; i < 11; i++) tick(1'b1, 1'b1);
    chk_int("bounce_glitches", n_glitch[0], 2);
    chk_int("bounce_rises", n_rise[0], 1);
    chk_int("bounce_rise_edge", rise_edge[0], 9);
    chk_int("bounce_falls", n_fall[0], 0);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);

    // Reset while the 2/4 instance is mid-check with two samples counted.
    clear_counts();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    chk_int("pre_reset_rises", n_rise[0], 0);
    tick(1'b0, 1'b1);
    chk4("reset_mid_a", {clean_a, rise_a, fall_a, glitch_a}, 4'b0000);
    chk4("reset_mid_b", {clean_b, rise_b, fall_b, glitch_b}, 4'b0000);
    clear_counts();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    chk_int("post_reset_strobes_a", n_rise[0] + n_fall[0] + n_glitch[0] + n_high[0], 0);
    chk_int("post_reset_strobes_b", n_rise[1] + n_fall[1] + n_glitch[1] + n_high[1], 0);

    // One-cycle pulse: accepted by the 3/1 instance, rejected as a glitch by the 2/4 one.
    clear_counts();
    tick(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    chk_int("pulse_b_rise", n_rise[1], 1);
    chk_int("pulse_b_rise_edge", rise_edge[1], 3);
    chk_int("pulse_b_fall_edge", fall_edge[1], 4);
    chk_int("pulse_b_high_cycles", n_high[1], 1);
    chk_int("pulse_b_glitch", n_glitch[1], 0);
    chk_int("pulse_a_glitch", n_glitch[0], 1);
    chk_int("pulse_a_rise", n_rise[0], 0);

    // Random bursts with occasional reset, checked every edge against the model.
    for (int i = 0; i < 300; i++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int j = 0; j < len; j++) tick(($urandom_range(0, 199) != 0), lvl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
